// File: rtl/stream_mux_arb.sv
// N-input stream multiplexer with sel-directed or round-robin arbitration.
// The chosen word lands in a one-entry output register that runs at full throughput.
module stream_mux_arb #(
   parameter  int WIDTH = 4,
   parameter  int N_IN  = 4,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   output logic [N_IN-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_src
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] grant;
   logic             grant_vld;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;

   assign out_valid = (state == FULL);
   assign load_en   = (state == EMPTY) || out_ready;

   always_comb begin
      logic [SEL_W-1:0] idx;
      int               t;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      t         = 0;
      if (!mode) begin
         if (int'(sel) < N_IN) begin
            if (in_valid[sel]) begin
               grant     = sel;
               grant_vld = 1'b1;
            end
         end
      end else begin
         // Walk forward from the channel after the last winner.
         for (int k = 1; k <= N_IN; k++) begin
            t = int'(rr_ptr) + k;
            if (t >= N_IN) t = t - N_IN;
            idx = SEL_W'(t);
            if (!grant_vld && in_valid[idx]) begin
               grant     = idx;
               grant_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_IN; i++) begin
         in_ready[i] = load_en && grant_vld && (grant == SEL_W'(i));
      end
   end

   assign xfer     = |in_ready;
   assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];

   always_comb begin
      state_nxt = state;
      if (xfer) begin
         state_nxt = FULL;
      end else if (state == FULL && out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_src  <= '0;
         rr_ptr   <= SEL_W'(N_IN - 1);
      end else if (xfer) begin
         out_data <= sel_data;
         out_src  <= grant;
         if (mode) rr_ptr <= grant;
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: directed vectors push expected words,
// a negedge monitor pops them as the consumer accepts each output word.
module tb_stream_mux_arb;

   localparam int WIDTH = 4;
   localparam int N_IN  = 4;
   localparam int SEL_W = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_src;

   int n_cmp = 0;
   int n_err = 0;
   logic [SEL_W+WIDTH-1:0] exp_q[$];

   stream_mux_arb #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_src(out_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One arbitration cycle: drive, check in_ready, optionally push expectation.
   task automatic cyc(input string name, input logic m, input logic [SEL_W-1:0] s,
                      input logic [N_IN-1:0] v, input logic ord,
                      input logic [N_IN*WIDTH-1:0] d,
                      input logic [N_IN-1:0] exp_rdy, input bit push,
                      input logic [SEL_W-1:0] e_src, input logic [WIDTH-1:0] e_dat);
      @(posedge clk);
      #1;
      mode = m; sel = s; in_valid = v; out_ready = ord; in_data = d;
      #1;
      chk({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      if (push) exp_q.push_back({e_src, e_dat});
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected word", 32'({out_src, out_data}), 32'hFFFF);
         end else begin
            logic [SEL_W+WIDTH-1:0] e;
            e = exp_q.pop_front();
            chk("out_src", 32'(out_src), 32'(e[SEL_W+WIDTH-1:WIDTH]));
            chk("out_data", 32'(out_data), 32'(e[WIDTH-1:0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   localparam logic [15:0] D_SEL = 16'hBA98;
   localparam logic [15:0] D_RR  = 16'h4321;

   initial begin
      rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0;
      out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst out_data", 32'(out_data), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         cyc("idle", 1'b0, 2'd0, 4'b0000, 1'b1, 16'h0, 4'b0000, 0, 0, 0);
         chk("idle out_valid", 32'(out_valid), 0);
         chk("idle out_data", 32'(out_data), 0);
         chk("idle out_src", 32'(out_src), 0);
      end

      cyc("sel2", 1'b0, 2'd2, 4'b1111, 1'b1, D_SEL, 4'b0100, 1, 2, 4'hA);
      cyc("sel3", 1'b0, 2'd3, 4'b1111, 1'b1, D_SEL, 4'b1000, 1, 3, 4'hB);
      chk("sel3 out_valid", 32'(out_valid), 1);
      cyc("sel idle ch", 1'b0, 2'd1, 4'b1101, 1'b1, D_SEL, 4'b0000, 0, 0, 0);
      cyc("drain", 1'b0, 2'd0, 4'b0000, 1'b1, D_SEL, 4'b0000, 0, 0, 0);
      chk("drain out_valid", 32'(out_valid), 0);
      chk("drain holds src", 32'(out_src), 3);

      cyc("rr0", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b0001, 1, 0, 4'h1);
      cyc("rr1", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b0010, 1, 1, 4'h2);
      cyc("rr2", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b0100, 1, 2, 4'h3);
      cyc("rr3", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b1000, 1, 3, 4'h4);
      cyc("rr0b", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b0001, 1, 0, 4'h1);

      cyc("alt1", 1'b1, 2'd0, 4'b1010, 1'b1, D_RR, 4'b0010, 1, 1, 4'h2);
      cyc("alt3", 1'b1, 2'd0, 4'b1010, 1'b1, D_RR, 4'b1000, 1, 3, 4'h4);
      cyc("alt1b", 1'b1, 2'd0, 4'b1010, 1'b1, D_RR, 4'b0010, 1, 1, 4'h2);
      cyc("alt3b", 1'b1, 2'd0, 4'b1010, 1'b1, D_RR, 4'b1000, 1, 3, 4'h4);
      for (int i = 0; i < 3; i++)
         cyc("only1", 1'b1, 2'd0, 4'b0010, 1'b1, D_RR, 4'b0010, 1, 1, 4'h2);

      cyc("bp load", 1'b1, 2'd0, 4'b0001, 1'b1, 16'h4325, 4'b0001, 1, 0, 4'h5);
      for (int i = 0; i < 3; i++) begin
         cyc("bp stall", 1'b1, 2'd0, 4'b0001, 1'b0, 16'h4326, 4'b0000, 0, 0, 0);
         chk("bp out_data", 32'(out_data), 5);
         chk("bp out_valid", 32'(out_valid), 1);
      end
      cyc("bp release", 1'b1, 2'd0, 4'b0001, 1'b1, 16'h4326, 4'b0001, 1, 0, 4'h6);
      cyc("bp nobubble", 1'b1, 2'd0, 4'b0000, 1'b1, D_RR, 4'b0000, 0, 0, 0);
      chk("nobubble valid", 32'(out_valid), 1);
      chk("nobubble data", 32'(out_data), 6);
      cyc("bp drain", 1'b1, 2'd0, 4'b0000, 1'b1, D_RR, 4'b0000, 0, 0, 0);

      cyc("pre rst", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b0010, 1, 1, 4'h2);
      cyc("hold", 1'b1, 2'd0, 4'b0000, 1'b0, D_RR, 4'b0000, 0, 0, 0);
      chk("hold valid", 32'(out_valid), 1);
      rst = 1'b1;
      void'(exp_q.pop_back());
      #1;
      chk("async rst valid", 32'(out_valid), 0);
      chk("async rst data", 32'(out_data), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc("post rst", 1'b1, 2'd0, 4'b1111, 1'b1, D_RR, 4'b0001, 1, 0, 4'h1);
      cyc("post drain", 1'b1, 2'd0, 4'b0000, 1'b1, D_RR, 4'b0000, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("queue empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
